// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: opcode classes, register index and data widths.
// Used by the hazard scoreboard and the result-forwarding logic.
package pipeline_pkg;

    localparam int REG_INDEX_BIT_WIDTH = 4;
    localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;
    localparam int DATA_W = 32;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SW = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_LW = 4'b0100;

    function automatic logic writes_reg(input logic [OPCODE_W-1:0] op);
        return !(op == OP_BRANCH || op == OP_SW);
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One register's scoreboard slot: in-flight write count and
// remaining load-use stall cycles.
module scoreboard_entry #(
    parameter int PEND_W = 2,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inc,
    input  logic              dec,
    input  logic              load,
    output logic [PEND_W-1:0] pending,
    output logic [1:0]        ld_cnt
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pending <= '0;
            ld_cnt  <= 2'd0;
        end else begin
            // same-cycle issue and retire cancel out
            if (inc && !dec)
                pending <= pending + 1'b1;
            else if (dec && !inc && pending != '0)
                pending <= pending - 1'b1;

            if (load)
                ld_cnt <= 2'(LOAD_USE_STALL);
            else if (ld_cnt != 2'd0)
                ld_cnt <= ld_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: load-use and pending-overflow stalls.
// Optional stall counter: HAZARD_SCOREBOARD_STALL_COUNTER_EN.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int PEND_W = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    input  logic [OPCODE_W-1:0]            id_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_dest,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2,
    input  logic                           id_src2_used,
    input  logic                           wb_valid,
    input  logic [OPCODE_W-1:0]            wb_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_index,
    input  logic                           flush,
    output logic                           stall,
    output logic [NUM_REGS-1:0]            pending_vec,
`ifdef HAZARD_SCOREBOARD_STALL_COUNTER_EN
    output logic [DATA_W-1:0]              stall_count,
`endif
    output logic                           busy
);

    logic [PEND_W-1:0] pending [NUM_REGS];
    logic [1:0]        ld_cnt  [NUM_REGS];

    logic id_writes;
    logic wb_writes;
    logic issue;

    assign id_writes = writes_reg(id_opcode);
    assign wb_writes = writes_reg(wb_opcode);

    assign stall = id_valid && (
        (ld_cnt[id_src1] != 2'd0) ||
        (id_src2_used && ld_cnt[id_src2] != 2'd0) ||
        (id_writes && pending[id_dest] == '1));

    assign issue = id_valid && !stall && !flush;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        logic inc;
        logic dec;
        logic load;

        assign inc  = issue && id_writes &&
                      id_dest == REG_INDEX_BIT_WIDTH'(r);
        assign load = inc && id_opcode == OP_LW;
        assign dec  = wb_valid && wb_writes &&
                      wb_index == REG_INDEX_BIT_WIDTH'(r);

        scoreboard_entry #(
            .PEND_W(PEND_W),
            .LOAD_USE_STALL(LOAD_USE_STALL)
        ) u_entry (
            .clk(clk),
            .reset(reset),
            .flush(flush),
            .inc(inc),
            .dec(dec),
            .load(load),
            .pending(pending[r]),
            .ld_cnt(ld_cnt[r])
        );

        assign pending_vec[r] = pending[r] != '0;
    end

    assign busy = |pending_vec;

`ifdef HAZARD_SCOREBOARD_STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall)
            stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Define HAZARD_SCOREBOARD_STALL_COUNTER_EN to cover the stall counter.
module tb_hazard_scoreboard;
    import pipeline_pkg::*;

    localparam int LUS = 1;
    localparam logic [3:0] OP_ADD = 4'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_dest;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_src2_used;
    logic        wb_valid;
    logic [3:0]  wb_opcode;
    logic [3:0]  wb_index;
    logic        flush;
    logic        stall;
    logic [15:0] pending_vec;
    logic        busy;
`ifdef HAZARD_SCOREBOARD_STALL_COUNTER_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .LOAD_USE_STALL(LUS),
        .PEND_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .id_opcode(id_opcode),
        .id_dest(id_dest),
        .id_src1(id_src1),
        .id_src2(id_src2),
        .id_src2_used(id_src2_used),
        .wb_valid(wb_valid),
        .wb_opcode(wb_opcode),
        .wb_index(wb_index),
        .flush(flush),
        .stall(stall),
        .pending_vec(pending_vec),
`ifdef HAZARD_SCOREBOARD_STALL_COUNTER_EN
        .stall_count(stall_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op,
                          input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic u);
        id_valid = v;
        id_opcode = op;
        id_dest = d;
        id_src1 = s1;
        id_src2 = s2;
        id_src2_used = u;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] op,
                          input logic [3:0] idx);
        wb_valid = v;
        wb_opcode = op;
        wb_index = idx;
    endtask

    task automatic idle();
        set_id(1'b0, OP_ADD, 4'h0, 4'h0, 4'h0, 1'b0);
        set_wb(1'b0, OP_ADD, 4'h0);
        flush = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        // reset with arbitrary inputs
        reset = 1'b1;
        flush = 1'b1;
        set_id(1'b1, OP_LW, 4'h5, 4'h5, 4'h5, 1'b1);
        set_wb(1'b1, OP_ADD, 4'h5);
        tick();
        tick();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pv", 32'(pending_vec), 32'h0);
        idle();

        // load-use on r5
        set_id(1'b1, OP_LW, 4'h5, 4'h1, 4'h2, 1'b0);
        settle();
        check("lw_nostall", 32'(stall), 32'd0);
        tick();
        set_id(1'b1, OP_ADD, 4'h6, 4'h5, 4'h2, 1'b0);
        for (int i = 0; i < LUS; i++) begin
            settle();
            check("lu_stall", 32'(stall), 32'd1);
            check("lu_pv", 32'(pending_vec), 32'h0020);
            tick();
        end
        settle();
        check("lu_release", 32'(stall), 32'd0);
        tick();
        idle();
        set_wb(1'b1, OP_LW, 4'h5);
        settle();
        check("pv_pre_wb", 32'(pending_vec), 32'h0060);
        tick();
        set_wb(1'b1, OP_ADD, 4'h6);
        settle();
        check("pv_wb5", 32'(pending_vec), 32'h0040);
        tick();
        idle();
        settle();
        check("pv_drained", 32'(pending_vec), 32'h0);
        check("busy_drained", 32'(busy), 32'd0);

        // non-writers
        set_id(1'b1, OP_SW, 4'h5, 4'h5, 4'h5, 1'b1);
        settle();
        check("sw_stall", 32'(stall), 32'd0);
        tick();
        set_id(1'b1, OP_BRANCH, 4'h3, 4'h5, 4'h0, 1'b0);
        settle();
        check("br_stall", 32'(stall), 32'd0);
        tick();
        idle();
        settle();
        check("nonwr_pv", 32'(pending_vec), 32'h0);

        // pending saturation on r3
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, OP_ADD, 4'h3, 4'h1, 4'h2, 1'b1);
            settle();
            check("wr3_stall", 32'(stall), 32'd0);
            tick();
        end
        check("pv_r3", 32'(pending_vec), 32'h0008);
        set_id(1'b1, 4'h1, 4'h3, 4'h1, 4'h2, 1'b1);
        set_wb(1'b1, OP_ADD, 4'h3);
        settle();
        check("full_stall", 32'(stall), 32'd1);
        tick();
        set_wb(1'b0, OP_ADD, 4'h0);
        settle();
        check("full_release", 32'(stall), 32'd0);
        tick();
        set_id(1'b1, OP_ADD, 4'h3, 4'h1, 4'h2, 1'b1);
        settle();
        check("full_again", 32'(stall), 32'd1);
        set_id(1'b0, OP_ADD, 4'h0, 4'h0, 4'h0, 1'b0);
        set_wb(1'b1, OP_ADD, 4'h3);
        repeat (3) tick();
        idle();
        settle();
        check("r3_drained", 32'(pending_vec), 32'h0);

        // retire underflow, then same-cycle issue and retire
        set_wb(1'b1, OP_ADD, 4'h9);
        tick();
        idle();
        settle();
        check("underflow", 32'(pending_vec), 32'h0);
        set_id(1'b1, OP_ADD, 4'h9, 4'h0, 4'h0, 1'b0);
        tick();
        set_wb(1'b1, OP_ADD, 4'h9);
        tick();
        idle();
        settle();
        check("cancel_pv", 32'(pending_vec), 32'h0200);
        set_wb(1'b1, OP_ADD, 4'h9);
        tick();
        idle();
        settle();
        check("r9_drained", 32'(pending_vec), 32'h0);

        // flush during load-use stall
        set_id(1'b1, OP_LW, 4'h7, 4'h0, 4'h0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 4'h8, 4'h0, 4'h7, 1'b1);
        flush = 1'b1;
        settle();
        check("fl_stall", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        settle();
        check("fl_after", 32'(stall), 32'd0);
        check("fl_pv", 32'(pending_vec), 32'h0);
        check("fl_busy", 32'(busy), 32'd0);
        idle();

        // src2 ignored when unused
        set_id(1'b1, OP_LW, 4'h8, 4'h0, 4'h0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 4'h9, 4'h0, 4'h8, 1'b0);
        settle();
        check("src2_unused", 32'(stall), 32'd0);
        id_src2_used = 1'b1;
        settle();
        check("src2_used", 32'(stall), 32'd1);
        id_valid = 1'b0;
        flush = 1'b1;
        tick();
        idle();

        // reset mid-stall
        set_id(1'b1, OP_LW, 4'h4, 4'h0, 4'h0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 4'h5, 4'h4, 4'h0, 1'b0);
        settle();
        check("rs_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rs_after", 32'(stall), 32'd0);
        check("rs_pv", 32'(pending_vec), 32'h0);
        idle();

`ifdef HAZARD_SCOREBOARD_STALL_COUNTER_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("sc_reset", stall_count, 32'd0);
        set_id(1'b1, OP_LW, 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 4'h2, 4'h1, 4'h0, 1'b0);
        repeat (LUS + 1) tick();
        set_id(1'b1, OP_LW, 4'h3, 4'h0, 4'h0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 4'h4, 4'h0, 4'h3, 1'b1);
        repeat (LUS + 1) tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        check("sc_pairs", stall_count, 32'(2 * LUS));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-side companion to the result-forwarding path in the 4-bit-opcode, 16-register, 32-bit pipeline.
- Tracks in-flight destination-register writes from ID issue to WB retire.
- Raises `stall` when a decoded instruction reads a register whose load result cannot yet be forwarded (load-use), or when the per-register tracking would overflow.
- Sits beside the ID/EX pipeline register; `stall` freezes the PC and IF/ID and injects a bubble into EX.

Parameters:
- REG_INDEX_BIT_WIDTH, 4, register index width.
- NUM_REGS, 16, number of tracked registers (2**REG_INDEX_BIT_WIDTH).
- LOAD_USE_STALL, 1, stall cycles owed by a consumer issued directly behind a load (range 1..3).
- PEND_W, 2, width of per-register in-flight write counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_opcode  input  4  opcode in ID.
- id_dest  input  REG_INDEX_BIT_WIDTH  destination register in ID.
- id_src1  input  REG_INDEX_BIT_WIDTH  first source register in ID.
- id_src2  input  REG_INDEX_BIT_WIDTH  second source register in ID.
- id_src2_used  input  1  id_src2 is a real operand.
- wb_valid  input  1  WB retiring an instruction this cycle.
- wb_opcode  input  4  opcode retiring in WB.
- wb_index  input  REG_INDEX_BIT_WIDTH  destination register retiring in WB.
- flush  input  1  pipeline squash; all in-flight instructions discarded.
- stall  output  1  hold ID and insert bubble (combinational from state plus ID inputs).
- pending_vec  output  NUM_REGS  bit r = pending[r] != 0 (registered state).
- busy  output  1  OR of pending_vec.

Behaviour:
- Opcode classes:
  - OP_BRANCH (4'b0010) and OP_SW (4'b0011) write no register.
  - OP_LW (4'b0100) is a load.
  - All other opcodes write id_dest.
- Per-register state:
  - pending[r] (PEND_W bits): writes in flight.
  - ld_cnt[r] (2 bits): remaining load-use stall cycles.
- Reset (synchronous, active-high): all pending and ld_cnt = 0, so stall = 0, pending_vec = 0, busy = 0. Reset mid-stall clears the stall the next cycle.
- stall = id_valid AND (any of the following):
  - ld_cnt[id_src1] != 0;
  - id_src2_used and ld_cnt[id_src2] != 0;
  - the instruction writes a register and pending[id_dest] == max (3).
- issue = id_valid AND NOT stall AND NOT flush.
- On issue of a register-writing opcode:
  - pending[id_dest] increments.
  - If the opcode is OP_LW, ld_cnt[id_dest] is loaded with LOAD_USE_STALL.
- Every cycle, each nonzero ld_cnt not being reloaded decrements by 1. A reload wins over a decrement.
- On wb_valid with a register-writing wb_opcode, pending[wb_index] decrements.
  - If pending is already 0, it stays 0. This is an error case; the bench flags it.
- Issue and WB to the same register in the same cycle: the increment and decrement cancel and pending is unchanged.
- Latency:
  - A load issued in cycle t stalls a dependent consumer presented in cycles t+1 .. t+LOAD_USE_STALL.
  - The consumer issues in cycle t+LOAD_USE_STALL+1.
  - Non-load producers never cause a stall; forwarding covers them.
- flush (highest priority after reset): next cycle all pending and ld_cnt = 0; the ID instruction does not issue. A squashed instruction must not later assert wb_valid.
- Register 0 gets no special treatment.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_STALL_COUNTER_EN.
- With the macro defined:
  - Extra output stall_count (32 bits).
  - It increments each cycle stall = 1, wraps at 2**32, and resets to 0 on reset. flush does not clear it.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - opcode constants OP_BRANCH, OP_SW, OP_LW;
  - the writes-register classification function;
  - REG_INDEX_BIT_WIDTH and data-width constants, also used by the forwarding logic.
- Sub-module scoreboard_entry:
  - Holds one register's pending and ld_cnt with inc, dec, load, flush and reset inputs.
  - Instantiated NUM_REGS times via generate; the top level keeps the decode, stall compare and OR-reduce.

Test Plan:
- Reset with every other input driven arbitrarily → stall=0, busy=0 and pending_vec=16'h0000 on the next cycle.
- Issue LW to r5 at t, then ADD reading src1=r5 at t+1 → stall=1 in cycle t+1 only; ADD issues at t+2; pending_vec[5]=1 until the WB of r5.
- Issue SW reading r5 with id_dest=r5, and a BRANCH → pending_vec stays 0, no stall.
- Three ALU ops writing r3 back-to-back with no WB → pending[3]=3; a fourth writer to r3 stalls; WB of r3 in that cycle → fourth issues the next cycle with pending[3] held at 3.
- LW to r7, consumer reading r7 stalled, flush asserted in the stall cycle → next cycle stall=0, pending_vec=0, busy=0.
- With HAZARD_SCOREBOARD_STALL_COUNTER_EN and LOAD_USE_STALL=2: two load-use pairs → stall_count=4.
